// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI3 read channel (AR/R) among N_REQ
// requesters. One transaction is outstanding at a time; the requester index
// is used as ARID, and R beats are steered back to the current owner.
module axi_rd_arbiter #(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned ID_W  = 4
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ*32-1:0]  req_addr,
    input  logic [N_REQ*4-1:0]   req_len,
    input  logic [N_REQ*3-1:0]   req_size,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     beat_valid,
    output logic [31:0]          beat_data,
    output logic                 beat_last,
    output logic [N_REQ-1:0]     done,
    output logic                 err,
    output logic [ID_W-1:0]      arid,
    output logic [31:0]          araddr,
    output logic [3:0]           arlen,
    output logic [2:0]           arsize,
    output logic [1:0]           arburst,
    output logic [1:0]           arlock,
    output logic [3:0]           arcache,
    output logic [2:0]           arprot,
    output logic                 arvalid,
    input  logic                 arready,
    input  logic [ID_W-1:0]      rid,
    input  logic [31:0]          rdata,
    input  logic [1:0]           rresp,
    input  logic                 rlast,
    input  logic                 rvalid,
    output logic                 rready
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_e;

    state_e           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [31:0]      araddr_q, araddr_d;
    logic [3:0]       arlen_q, arlen_d;
    logic [2:0]       arsize_q, arsize_d;
    logic [ID_W-1:0]  arid_q, arid_d;
    logic [3:0]       cnt_q, cnt_d;

    logic [31:0]      addr_a [N_REQ];
    logic [3:0]       len_a  [N_REQ];
    logic [2:0]       size_a [N_REQ];
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             beat_fire;

    // Unpack the flat per-requester request buses into indexable arrays
    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            addr_a[i] = req_addr[i*32 +: 32];
            len_a[i]  = req_len[i*4 +: 4];
            size_a[i] = req_size[i*3 +: 3];
        end
    end

    // Round-robin pick: first set req bit scanning upward from last+1 with wrap
    always_comb begin
        int unsigned      cand;
        logic [IDX_W-1:0] cidx;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cidx       = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = (32'(last_q) + k) % N_REQ;
            cidx = IDX_W'(cand);
            if (!pick_found && req[cidx]) begin
                pick_found = 1'b1;
                pick_idx   = cidx;
            end
        end
    end

    // State register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_found) state_d = ADDR;
            ADDR:    if (arready) state_d = DATA;
            DATA:    if (beat_fire && rlast) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: handshakes, beat steering and protocol error detection
    always_comb begin
        arvalid    = (state_q == ADDR);
        rready     = (state_q == DATA);
        beat_fire  = rvalid && rready;
        beat_valid = beat_fire ? gnt_q : '0;
        beat_data  = rdata;
        beat_last  = beat_fire && rlast;
        done       = (state_q == DONE) ? gnt_q : '0;
        err        = beat_fire && ((rresp != 2'b00) || (rid != arid_q) ||
                                   (rlast && (cnt_q != arlen_q)) ||
                                   (!rlast && (cnt_q == arlen_q)));
    end

    // Datapath next values: capture owner request on grant, count beats
    always_comb begin
        gnt_d    = gnt_q;
        last_d   = last_q;
        araddr_d = araddr_q;
        arlen_d  = arlen_q;
        arsize_d = arsize_q;
        arid_d   = arid_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    last_d          = pick_idx;
                    araddr_d        = addr_a[pick_idx];
                    arlen_d         = len_a[pick_idx];
                    arsize_d        = size_a[pick_idx];
                    arid_d          = ID_W'(pick_idx);
                end
            end
            ADDR:    if (arready) cnt_d = '0;
            DATA:    if (beat_fire) cnt_d = cnt_q + 4'd1;
            DONE:    gnt_d = '0;
            default: ;
        endcase
    end

    // Datapath registers; pointer resets to N_REQ-1 so requester 0 wins first
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            gnt_q    <= '0;
            last_q   <= IDX_W'(N_REQ - 1);
            araddr_q <= '0;
            arlen_q  <= '0;
            arsize_q <= '0;
            arid_q   <= '0;
            cnt_q    <= '0;
        end else begin
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            araddr_q <= araddr_d;
            arlen_q  <= arlen_d;
            arsize_q <= arsize_d;
            arid_q   <= arid_d;
            cnt_q    <= cnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign araddr  = araddr_q;
    assign arlen   = arlen_q;
    assign arsize  = arsize_q;
    assign arid    = arid_q;
    assign arburst = 2'b01;
    assign arlock  = '0;
    assign arcache = '0;
    assign arprot  = '0;

endmodule
